axis_pkt_fifo_s: RTL and testbench

- Parametrised AXI4-Stream packet FIFO: slave side sinks TLAST-delimited packets, master side forwards only fully received (committed) packets (store-and-forward).
- Successor to the fixed-width AXIS slave sink: adds configurable width and depth, a TKEEP path, packet accounting, and oversize-packet drop.
- Sits between a stream source and a downstream consumer that must never see partial packets.

---
 rtl/axis_pkt_fifo_pkg.sv | 28 ++
 rtl/axis_pkt_fifo_mem.sv | 32 +++
 rtl/axis_pkt_fifo_s.sv | 170 +++++++++++++++++
 tb/tb_axis_pkt_fifo_s.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and width helpers for the AXI4-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  // Slave-side state: FILL stores beats, DROP discards the rest of an oversize packet
  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits = bits + 1;
    return bits;
  endfunction

  // Pointer width: address bits plus one wrap bit to separate full from empty
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  // One TKEEP bit per data byte
  function automatic int unsigned keep_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Simple dual-port beat storage: synchronous write, registered read.
// Contents are not reset; only the read register is cleared.
module axis_pkt_fifo_mem
  import axis_pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; it holds its value until the next read, so it doubles as the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_pkt_fifo_s.sv
// AXI4-Stream store-and-forward packet FIFO.
// Only packets whose TLAST beat has been stored are forwarded; a packet that
// cannot fit in the whole FIFO is dropped and counted.
// Optional macro AXIS_PKT_FIFO_BAD_DROP_EN: a TLAST beat with TUSER=1 discards
// its packet instead of committing it.
module axis_pkt_fifo_s
  import axis_pkt_fifo_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH       = 64,
  parameter int C_DROP_CNT_WIDTH   = 16
) (
  input  logic                                       ACLK,
  input  logic                                       ARESETN,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]              S_AXIS_TDATA,
  input  logic [keep_width(C_AXIS_TDATA_WIDTH)-1:0]  S_AXIS_TKEEP,
  input  logic                                       S_AXIS_TLAST,
  input  logic                                       S_AXIS_TUSER,
  input  logic                                       S_AXIS_TVALID,
  output logic                                       S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]              M_AXIS_TDATA,
  output logic [keep_width(C_AXIS_TDATA_WIDTH)-1:0]  M_AXIS_TKEEP,
  output logic                                       M_AXIS_TLAST,
  output logic                                       M_AXIS_TVALID,
  input  logic                                       M_AXIS_TREADY,
  output logic [ptr_width(C_FIFO_DEPTH)-1:0]         occupancy,
  output logic [ptr_width(C_FIFO_DEPTH)-1:0]         pkt_count,
  output logic                                       ovf_flag,
  input  logic                                       ovf_clr,
  output logic [C_DROP_CNT_WIDTH-1:0]                drop_cnt
);

  localparam int unsigned AW = clog2(C_FIFO_DEPTH);
  localparam int unsigned PW = ptr_width(C_FIFO_DEPTH);
  localparam int unsigned KW = keep_width(C_AXIS_TDATA_WIDTH);
  localparam int unsigned EW = C_AXIS_TDATA_WIDTH + KW + 1;

  localparam logic [PW-1:0]               DEPTH_LVL = PW'(C_FIFO_DEPTH);
  localparam logic [PW-1:0]               PTR_ONE   = PW'(1);
  localparam logic [C_DROP_CNT_WIDTH-1:0] CNT_ONE   = C_DROP_CNT_WIDTH'(1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fill_lvl;
  logic          armed;
  logic          s_ready;
  logic          full;
  logic          s_fire;
  logic          s_fire_last;
  logic          bad_last;
  logic          ovf_det;
  logic          commit;
  logic          bad_drop;
  logic          mem_wr;
  logic          load;
  logic          m_valid;
  logic          m_last_fire;
  logic [EW-1:0] rd_entry;

`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  assign bad_last = S_AXIS_TUSER;
`else
  logic unused_tuser;
  assign unused_tuser = S_AXIS_TUSER;
  assign bad_last     = 1'b0;
`endif

  assign fill_lvl    = wr_ptr - rd_ptr;
  assign full        = (fill_lvl == DEPTH_LVL);
  assign s_fire      = S_AXIS_TVALID & s_ready;
  assign s_fire_last = s_fire & S_AXIS_TLAST;
  // Full with nothing committed: every stored beat belongs to the open packet
  assign ovf_det     = (state == FILL) & full & (commit_ptr == rd_ptr) & S_AXIS_TVALID;
  assign commit      = (state == FILL) & s_fire_last & ~bad_last;
  assign bad_drop    = (state == FILL) & s_fire_last & bad_last;
  assign mem_wr      = (state == FILL) & s_fire;
  assign load        = (rd_ptr != commit_ptr) & (~m_valid | M_AXIS_TREADY);
  assign m_last_fire = m_valid & M_AXIS_TREADY & M_AXIS_TLAST;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= FILL;
    else          state <= state_nxt;
  end

  // Next-state: enter DROP on overflow, leave once the dropped packet's TLAST is taken
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (ovf_det)     state_nxt = DROP;
      DROP: if (s_fire_last) state_nxt = FILL;
      default:               state_nxt = FILL;
    endcase
  end

  // Slave ready: held low in reset and the first cycle after, never depends on TVALID
  always_comb begin
    s_ready = 1'b0;
    if (armed) s_ready = (state == DROP) | ~full;
  end

  assign S_AXIS_TREADY = s_ready;

  // Ready enable, set one cycle after reset release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  // Write and commit pointers; dropping a packet rewinds the write pointer to the last commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else if (ovf_det || bad_drop) begin
      wr_ptr <= commit_ptr;
    end else if (mem_wr) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (commit) commit_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and output-stage valid
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (load) rd_ptr <= rd_ptr + PTR_ONE;
      m_valid <= load | (m_valid & ~M_AXIS_TREADY);
    end
  end

  // Packet accounting, sticky overflow flag and saturating drop counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_count <= '0;
      ovf_flag  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (commit && !m_last_fire)      pkt_count <= pkt_count + PTR_ONE;
      else if (!commit && m_last_fire) pkt_count <= pkt_count - PTR_ONE;
      if (ovf_det)      ovf_flag <= 1'b1;
      else if (ovf_clr) ovf_flag <= 1'b0;
      if ((ovf_det || bad_drop) && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  axis_pkt_fifo_mem #(
    .DATA_W (EW),
    .ADDR_W (AW)
  ) u_mem (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (mem_wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA}),
    .rd_en   (load),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = rd_entry;
  assign M_AXIS_TVALID = m_valid;
  assign occupancy     = fill_lvl;

endmodule

// File: tb/tb_axis_pkt_fifo_s.sv
// Scoreboard bench for axis_pkt_fifo_s (depth 16, 32-bit data).
// Define AXIS_PKT_FIFO_BAD_DROP_EN to also exercise the TUSER packet drop.
module tb_axis_pkt_fifo_s;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 16;
  localparam int PW    = 5;
  localparam int DCW   = 16;
`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_last = 1'b0;
  logic          s_user = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] pkt_count;
  logic          ovf_flag;
  logic          ovf_clr = 1'b0;
  logic [DCW-1:0] drop_cnt;

  always #5 clk = ~clk;

  axis_pkt_fifo_s #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_FIFO_DEPTH       (DEPTH),
    .C_DROP_CNT_WIDTH   (DCW)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TKEEP  (s_keep),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TUSER  (s_user),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TKEEP  (m_keep),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count),
    .ovf_flag      (ovf_flag),
    .ovf_clr       (ovf_clr),
    .drop_cnt      (drop_cnt)
  );

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    out_pkts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every handed-off beat with the scoreboard and check hold under backpressure
  beat_t held;
  logic  held_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("out_hold", {m_valid, m_last, m_keep, m_data}, {1'b1, held});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: beat 0x%0h presented with no complete packet expected", m_data);
        end else begin
          check("out_beat", {m_last, m_keep, m_data}, exp_q.pop_front());
          if (m_last) out_pkts++;
        end
      end
      held_v = m_valid && !m_ready;
      held   = '{last: m_last, keep: m_keep, data: m_data};
    end
  end

  // Present one beat and wait (bounded) for its handshake; returns at posedge+1
  task automatic send_beat(input beat_t b, input logic user, output logic ok);
    int cyc;
    cyc     = 0;
    ok      = 1'b0;
    s_data  = b.data;
    s_keep  = b.keep;
    s_last  = b.last;
    s_user  = user;
    s_valid = 1'b1;
    while (cyc < 2000) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_timeout: beat 0x%0h never accepted", b.data);
    end
    @(posedge clk);
    #1;
  endtask

  // Send a packet; reference rule: a packet longer than the FIFO depth, or one
  // flagged bad when that feature is built in, never reaches the output
  task automatic send_pkt(input int len, input bit bad, input int gap_pct, input bit seq,
                          input logic [DW-1:0] base);
    beat_t pkt[$];
    beat_t b;
    logic  ok;
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      b.data = seq ? base + DW'(i) : DW'($urandom);
      b.keep = seq ? '1 : KW'($urandom_range(0, 15));
      b.last = (i == len - 1);
      send_beat(b, bad && b.last, ok);
      pkt.push_back(b);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
    if (len <= DEPTH && !(bad && BAD_EN)) begin
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || m_valid) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit    rnd_on;
  int    p0;
  int    lat;
  beat_t b;
  logic  ok;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_beat", {m_last, m_keep, m_data}, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-beat packet 0x1..0x4: nothing out before TLAST, then consecutive beats
    m_ready = 1'b1;
    check("t1_pkt_count_before", pkt_count, 0);
    for (int i = 1; i <= 4; i++) begin
      check("t1_no_early_valid", m_valid, 0);
      b = '{last: (i == 4), keep: '1, data: DW'(i)};
      send_beat(b, 1'b0, ok);
      exp_q.push_back(b);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t1_pkt_count_commit", pkt_count, 1);
    check("t1_valid_after_last", m_valid, 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 10);
    check("t1_first_beat_latency_le2", lat <= 2, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_back_to_back", m_valid, 1);
    end
    @(negedge clk);
    check("t1_valid_after_pkt", m_valid, 0);
    check("t1_pkt_count_after", pkt_count, 0);
    wait_drain("t1_drain");

    // Eight 3-beat packets into a stalled consumer
    m_ready = 1'b0;
    p0 = out_pkts;
    fork
      begin
        for (int p = 0; p < 8; p++) send_pkt(3, 1'b0, 0, 1'b0, '0);
      end
      begin
        int cyc;
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!(s_valid && !s_ready) && cyc < 300);
        check("t2_stall_seen", s_valid && !s_ready, 1);
        check("t2_occupancy_full", occupancy, DEPTH);
        check("t2_pkt_count_full", pkt_count, 5);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_drain("t2_drain");
    check("t2_pkts_out", out_pkts - p0, 8);
    check("t2_pkt_count_end", pkt_count, 0);

    // Oversize 20-beat packet followed by a 2-beat packet
    p0 = out_pkts;
    send_pkt(20, 1'b0, 0, 1'b1, 32'h100);
    send_pkt(2, 1'b0, 0, 1'b1, 32'h200);
    wait_drain("t3_drain");
    check("t3_ovf_flag", ovf_flag, 1);
    check("t3_drop_cnt", drop_cnt, 1);
    check("t3_pkts_out", out_pkts - p0, 1);
    check("t3_occupancy_end", occupancy, 0);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", ovf_flag, 0);

    // Random lengths and random backpressure
    p0 = out_pkts;
    rnd_on = 1'b1;
    fork
      begin
        for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 12), 1'b0, 25, 1'b0, '0);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_pkts_out", out_pkts - p0, 100);
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_pkt_count_end", pkt_count, 0);

    // Reset with 2 of 5 beats written
    for (int i = 0; i < 2; i++) begin
      b = '{last: 1'b0, keep: 4'h5, data: 32'hDEAD_0000 + DW'(i)};
      send_beat(b, 1'b0, ok);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_partial_occupancy", occupancy, 2);
    check("t5_partial_no_output", m_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_occupancy", occupancy, 0);
    check("t5_rst_pkt_count", pkt_count, 0);
    check("t5_rst_m_valid", m_valid, 0);
    check("t5_rst_s_ready", s_ready, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = out_pkts;
    send_pkt(5, 1'b0, 0, 1'b1, 32'h300);
    wait_drain("t5_drain");
    check("t5_pkts_out", out_pkts - p0, 1);

`ifdef AXIS_PKT_FIFO_BAD_DROP_EN
    // Middle packet flagged bad on its TLAST beat
    p0 = out_pkts;
    send_pkt(3, 1'b0, 0, 1'b1, 32'h400);
    send_pkt(4, 1'b1, 0, 1'b1, 32'h500);
    send_pkt(2, 1'b0, 0, 1'b1, 32'h600);
    wait_drain("t6_drain");
    check("t6_pkts_out", out_pkts - p0, 2);
    check("t6_drop_cnt", drop_cnt, 1);
    check("t6_ovf_flag", ovf_flag, 0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
